// File: rtl/imc_pkg.sv
// Shared definitions for the IMC Wishbone bridge.
// Contents: FSM state encoding, status version constant, timeout read pattern,
// status word and core request payload layouts, saturating counter helper.
package imc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } imc_state_e;

    localparam logic [7:0]  IMC_VERSION         = 8'h01;
    localparam logic [31:0] IMC_TIMEOUT_PATTERN = 32'hDEAD_BEEF;

    // Status register layout as seen by a Wishbone read of the status offset
    typedef struct packed {
        logic [7:0] version;
        logic [7:0] abort_cnt;
        logic [7:0] timeout_cnt;
        logic [6:0] rsvd;
        logic       timeout_flag;
    } imc_status_t;

    // Request payload held toward the IMC core while a transfer is pending
    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } imc_core_req_t;

    // 8-bit event counter increment that sticks at all-ones
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/imc_wb_bridge_if.sv
// Wishbone classic slave bundle for the IMC bridge.
// master: drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o.
// slave : receives cyc/stb/we/sel/adr/dat_i, drives ack/dat_o.
interface imc_wb_bridge_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/imc_timeout_cnt.sv
// Wait-cycle counter for the IMC bridge with terminal-count compare.
// Ports: i_clk, i_rst (sync, active high), i_clr (restart at zero),
//        i_en (count one wait cycle), o_tc_c (combinational: current cycle is
//        the TERMINAL-th enabled cycle since the last clear).
module imc_timeout_cnt
    import imc_pkg::*;
#(
    parameter int unsigned TERMINAL = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counts elapsed wait cycles; parks on the terminal value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_cnt == LAST);

endmodule

// File: rtl/imc_wb_bridge.sv
// Wishbone classic slave bridge to the IMC core with a local status register.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wbs                : Wishbone slave bundle (imc_wb_bridge_if.slave)
//   core_req_o/we/sel/addr/wdata : request held toward the IMC core during WAIT
//   core_done_i, core_rdata_i    : completion and read data from the IMC core
//   irq_o              : one-cycle pulse per core timeout
module imc_wb_bridge
    import imc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK  = 32'hFFFF_0000,
    parameter logic [15:0] STATUS_OFS = 16'hFFFC,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    imc_wb_bridge_if.slave        wbs,
    output logic                  core_req_o,
    output logic                  core_we_o,
    output logic [3:0]            core_sel_o,
    output logic [31:0]           core_addr_o,
    output logic [31:0]           core_wdata_o,
    input  logic                  core_done_i,
    input  logic [31:0]           core_rdata_i,
    output logic                  irq_o
);

    logic        w_sel;
    logic        w_status_hit;
    logic        w_cnt_clr;
    logic        w_cnt_en;
    logic        w_tc;
    imc_status_t w_status;

    imc_state_e    r_state;
    imc_core_req_t r_core;
    logic          r_core_req;
    logic          r_ack;
    logic          r_irq;
    logic [31:0]   r_dat;
    logic          r_timeout_flag;
    logic [7:0]    r_timeout_cnt;
    logic [7:0]    r_abort_cnt;

    assign w_sel        = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                          ((wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign w_status_hit = (wbs.wbs_adr_i[15:0] == STATUS_OFS);
    assign w_cnt_clr    = (r_state == ST_IDLE) && w_sel && !w_status_hit;
    assign w_cnt_en     = (r_state == ST_WAIT);

    // Status word assembled from the sticky fields
    always_comb begin
        w_status              = '0;
        w_status.version      = IMC_VERSION;
        w_status.abort_cnt    = r_abort_cnt;
        w_status.timeout_cnt  = r_timeout_cnt;
        w_status.timeout_flag = r_timeout_flag;
    end

    imc_timeout_cnt #(
        .TERMINAL (TIMEOUT)
    ) u_timeout_cnt (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_tc_c (w_tc)
    );

    // Bridge FSM; ack/data/irq are single-cycle and default low every cycle.
    // r_dat doubles as the read register and is only non-zero while acking.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state        <= ST_IDLE;
            r_core         <= '0;
            r_core_req     <= 1'b0;
            r_ack          <= 1'b0;
            r_irq          <= 1'b0;
            r_dat          <= '0;
            r_timeout_flag <= 1'b0;
            r_timeout_cnt  <= '0;
            r_abort_cnt    <= '0;
        end else begin
            r_ack <= 1'b0;
            r_irq <= 1'b0;
            r_dat <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel && w_status_hit) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        if (!wbs.wbs_we_i) begin
                            r_dat <= w_status;
                        end else if (wbs.wbs_dat_i[0]) begin
                            r_timeout_flag <= 1'b0;
                            r_timeout_cnt  <= '0;
                            r_abort_cnt    <= '0;
                        end
                    end else if (w_sel) begin
                        r_state      <= ST_WAIT;
                        r_core_req   <= 1'b1;
                        r_core.we    <= wbs.wbs_we_i;
                        r_core.sel   <= wbs.wbs_sel_i;
                        r_core.addr  <= wbs.wbs_adr_i;
                        r_core.wdata <= wbs.wbs_dat_i;
                    end
                end
                ST_WAIT: begin
                    // Master abandoning the cycle beats any core response
                    if (!wbs.wbs_cyc_i) begin
                        r_state     <= ST_IDLE;
                        r_core_req  <= 1'b0;
                        r_abort_cnt <= sat_inc8(r_abort_cnt);
                    end else if (core_done_i) begin
                        r_state    <= ST_ACK;
                        r_core_req <= 1'b0;
                        r_ack      <= 1'b1;
                        r_dat      <= r_core.we ? 32'h0 : core_rdata_i;
                    end else if (w_tc) begin
                        r_state        <= ST_ACK;
                        r_core_req     <= 1'b0;
                        r_ack          <= 1'b1;
                        r_irq          <= 1'b1;
                        r_dat          <= IMC_TIMEOUT_PATTERN;
                        r_timeout_flag <= 1'b1;
                        r_timeout_cnt  <= sat_inc8(r_timeout_cnt);
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_core_req <= 1'b0;
                end
            endcase
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign core_req_o    = r_core_req;
    assign core_we_o     = r_core.we;
    assign core_sel_o    = r_core.sel;
    assign core_addr_o   = r_core.addr;
    assign core_wdata_o  = r_core.wdata;
    assign irq_o         = r_irq;

endmodule

// File: tb/tb_imc_wb_bridge.sv
// Self-checking bench for imc_wb_bridge: a transaction-level timeline model
// fills per-cycle expected outputs, one negedge process compares against them.
module tb_imc_wb_bridge;
    import imc_pkg::*;

    localparam int          T      = 16;
    localparam int          MAXC   = 16384;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] ST_ADR = 32'h3000_FFFC;

    logic        clk;
    logic        wb_rst_i;
    logic        core_req_o;
    logic        core_we_o;
    logic [3:0]  core_sel_o;
    logic [31:0] core_addr_o;
    logic [31:0] core_wdata_o;
    logic        core_done_i;
    logic [31:0] core_rdata_i;
    logic        irq_o;

    imc_wb_bridge_if bus ();

    imc_wb_bridge #(
        .BASE_ADDR  (BASE),
        .ADDR_MASK  (32'hFFFF_0000),
        .STATUS_OFS (16'hFFFC),
        .TIMEOUT    (T)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (wb_rst_i),
        .wbs          (bus),
        .core_req_o   (core_req_o),
        .core_we_o    (core_we_o),
        .core_sel_o   (core_sel_o),
        .core_addr_o  (core_addr_o),
        .core_wdata_o (core_wdata_o),
        .core_done_i  (core_done_i),
        .core_rdata_i (core_rdata_i),
        .irq_o        (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n = 0;
    always @(posedge clk) n <= n + 1;

    // Expected outputs per cycle index (index = posedges seen so far)
    bit        exp_ack   [MAXC];
    bit [31:0] exp_dat   [MAXC];
    bit        exp_req   [MAXC];
    bit        exp_irq   [MAXC];
    bit [31:0] exp_addr  [MAXC];
    bit [31:0] exp_wdata [MAXC];
    bit        exp_we    [MAXC];
    bit [3:0]  exp_sel   [MAXC];

    // Sticky status as the bench believes it to be
    int m_tflag = 0;
    int m_tcnt  = 0;
    int m_acnt  = 0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, n, got, want);
        end
    endtask

    function automatic logic [31:0] status_word();
        return {8'h01, 8'(m_acnt), 8'(m_tcnt), 7'd0, 1'(m_tflag)};
    endfunction

    always @(negedge clk) begin
        if (n > 0 && n < MAXC) begin
            chk("ack",   32'(bus.wbs_ack_o), 32'(exp_ack[n]));
            chk("dat_o", bus.wbs_dat_o,      exp_dat[n]);
            chk("req",   32'(core_req_o),    32'(exp_req[n]));
            chk("irq",   32'(irq_o),         32'(exp_irq[n]));
            if (exp_req[n]) begin
                chk("core_addr",  core_addr_o,       exp_addr[n]);
                chk("core_wdata", core_wdata_o,      exp_wdata[n]);
                chk("core_we",    32'(core_we_o),    32'(exp_we[n]));
                chk("core_sel",   32'(core_sel_o),   32'(exp_sel[n]));
            end
        end
    end

    task automatic drive_bus(input bit cyc, input bit stb, input bit we,
                             input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] wd);
        bus.wbs_cyc_i = cyc;
        bus.wbs_stb_i = stb;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wd;
    endtask

    task automatic idle_cycle();
        drive_bus(0, 0, 0, 4'h0, 32'h0, 32'h0);
        core_done_i  = 1'($urandom);
        core_rdata_i = $urandom;
        @(negedge clk);
    endtask

    task automatic exp_core(input int i, input bit we, input logic [31:0] adr,
                            input logic [31:0] wd, input logic [3:0] sel);
        if (i < MAXC) begin
            exp_req[i]   = 1'b1;
            exp_addr[i]  = adr;
            exp_wdata[i] = wd;
            exp_we[i]    = we;
            exp_sel[i]   = sel;
        end
    endtask

    // Status register access: acked in the cycle right after select
    task automatic status_access(input bit we, input logic [31:0] wd, output logic [31:0] got);
        int s;
        s = n + 1;
        if (s < MAXC) begin
            exp_ack[s] = 1'b1;
            exp_dat[s] = we ? 32'h0 : status_word();
        end
        if (we && wd[0]) begin
            m_tflag = 0;
            m_tcnt  = 0;
            m_acnt  = 0;
        end
        drive_bus(1, 1, we, 4'($urandom), ST_ADR, wd);
        core_done_i = 1'($urandom);
        @(negedge clk);
        got = bus.wbs_dat_o;
        idle_cycle();
    endtask

    // Core access: d = WAIT cycle in which done arrives (0 = never),
    // ab = WAIT cycle in which the master drops cyc (0 = never)
    task automatic core_access(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                               input logic [3:0] sel, input int d, input int ab,
                               input logic [31:0] rd, output logic [31:0] got);
        int s, fin, kind;
        s = n + 1;
        if (ab > 0 && ab < T && (d == 0 || ab < d)) begin
            kind = 2; fin = ab;
        end else if (d > 0 && d <= T) begin
            kind = 0; fin = d;
        end else begin
            kind = 1; fin = T;
        end
        for (int i = s; i < s + fin; i++) exp_core(i, we, adr, wd, sel);
        if (kind != 2 && s + fin < MAXC) begin
            exp_ack[s + fin] = 1'b1;
            exp_dat[s + fin] = (kind == 1) ? 32'hDEAD_BEEF : (we ? 32'h0 : rd);
            exp_irq[s + fin] = (kind == 1);
        end
        if (kind == 1) begin
            m_tflag = 1;
            if (m_tcnt < 255) m_tcnt++;
        end
        if (kind == 2 && m_acnt < 255) m_acnt++;
        drive_bus(1, 1, we, sel, adr, wd);
        core_done_i  = 1'($urandom);
        core_rdata_i = $urandom;
        @(negedge clk);
        for (int j = 1; j <= fin; j++) begin
            core_done_i  = (kind == 0 && j == fin);
            core_rdata_i = (kind == 0 && j == fin) ? rd : $urandom;
            if (kind == 2 && j == fin) drive_bus(0, 0, we, sel, adr, wd);
            @(negedge clk);
        end
        got = bus.wbs_dat_o;
        idle_cycle();
    endtask

    // Access that must not select the bridge
    task automatic miss_access(input logic [31:0] adr, input bit no_stb);
        drive_bus(1, !no_stb, 1'($urandom), 4'hF, adr, $urandom);
        repeat (3) begin
            core_done_i = 1'($urandom);
            @(negedge clk);
            chk("miss_ack", 32'(bus.wbs_ack_o), 32'h0);
            chk("miss_req", 32'(core_req_o),    32'h0);
        end
        idle_cycle();
    endtask

    initial begin
        logic [31:0] got, adr, wd;
        int s, k, d, ab;
        bit we;

        drive_bus(0, 0, 0, 4'h0, 32'h0, 32'h0);
        core_done_i  = 1'b0;
        core_rdata_i = 32'h0;
        wb_rst_i     = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req", 32'(core_req_o),  32'h0);
        chk("reset_addr", core_addr_o,     32'h0);
        wb_rst_i = 1'b0;

        status_access(0, 32'h0, got);
        chk("status_after_reset", got, 32'h0100_0000);

        core_access(1, 32'h3000_0010, 32'h0000_00A5, 4'hF, 3, 0, 32'h0, got);
        chk("write_ack_data", got, 32'h0);
        chk("write_addr_held", core_addr_o, 32'h3000_0010);
        chk("write_wdata_held", core_wdata_o, 32'h0000_00A5);

        core_access(0, 32'h3000_0020, 32'h0, 4'hF, 1, 0, 32'h1234_5678, got);
        chk("read_data", got, 32'h1234_5678);

        core_access(0, 32'h3000_0030, 32'h0, 4'hF, 0, 0, 32'h0, got);
        chk("timeout_data", got, 32'hDEAD_BEEF);
        status_access(0, 32'h0, got);
        chk("status_after_timeout", got, 32'h0100_0101);

        core_access(0, 32'h3000_0034, 32'h0, 4'hF, T, 0, 32'hCAFE_0001, got);
        chk("done_beats_timeout", got, 32'hCAFE_0001);

        core_access(0, 32'h3000_0038, 32'h0, 4'h3, 0, 2, 32'h0, got);
        status_access(0, 32'h0, got);
        chk("status_after_abort", got, 32'h0101_0101);
        status_access(1, 32'h0000_0001, got);
        status_access(0, 32'h0, got);
        chk("status_after_clear", got, 32'h0100_0000);

        // Reset in the middle of a WAIT after making the status non-zero
        core_access(0, 32'h3000_0040, 32'h0, 4'hF, 0, 0, 32'h0, got);
        s = n + 1;
        exp_core(s,     0, 32'h3000_0044, 32'h0, 4'hF);
        exp_core(s + 1, 0, 32'h3000_0044, 32'h0, 4'hF);
        drive_bus(1, 1, 0, 4'hF, 32'h3000_0044, 32'h0);
        @(negedge clk);
        core_done_i = 1'b0;
        @(negedge clk);
        wb_rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_req",  32'(core_req_o),       32'h0);
        chk("rst_mid_ack",  32'(bus.wbs_ack_o),    32'h0);
        chk("rst_mid_addr", core_addr_o,           32'h0);
        wb_rst_i = 1'b0;
        m_tflag = 0; m_tcnt = 0; m_acnt = 0;
        idle_cycle();
        status_access(0, 32'h0, got);
        chk("status_after_rst", got, 32'h0100_0000);

        miss_access(32'h3001_0000, 0);
        miss_access(32'h3000_0010, 1);

        // Saturation of both 8-bit counters
        repeat (260) core_access(0, 32'h3000_0100, 32'h0, 4'hF, 0, 0, 32'h0, got);
        repeat (260) core_access(1, 32'h3000_0104, 32'h5, 4'h1, 0, 1, 32'h0, got);
        status_access(0, 32'h0, got);
        chk("status_saturated", got, 32'h01FF_FF01);
        status_access(1, 32'h0000_0001, got);

        repeat (200) begin
            k = $urandom_range(0, 99);
            if (k < 12) begin
                status_access(0, 32'h0, got);
            end else if (k < 20) begin
                wd = $urandom;
                status_access(1, wd, got);
            end else if (k < 30) begin
                adr = $urandom;
                if (adr[31:16] == 16'h3000) adr[31:16] = 16'h3002;
                miss_access(adr, 1'($urandom));
            end else begin
                we  = 1'($urandom);
                adr = BASE | 32'($urandom_range(0, 16'hFFF0) & 32'hFFFC);
                d   = $urandom_range(0, T + 3);
                ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, T - 1) : 0;
                if (ab == d) ab = 0;
                core_access(we, adr, $urandom, 4'($urandom), d, ab, $urandom, got);
            end
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        status_access(0, 32'h0, got);
        repeat (3) idle_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imc_wb_bridge.md
IMC_WB_BRIDGE -- requirements
Module: imc_wb_bridge

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h3000_0000, Wishbone base address of the IMC window.
REQ-002 Parameter: ADDR_MASK, default 32'hFFFF_0000, bits compared against BASE_ADDR for select.
REQ-003 Parameter: STATUS_OFS, default 16'hFFFC, window offset of the local status register.
REQ-004 Parameter: TIMEOUT, default 255, maximum wait cycles for core_done_i.
REQ-005 Port wb_clk_i, input, 1, sole clock; all logic is synchronous to its rising edge.
REQ-006 Port wb_rst_i, input, 1, synchronous active-high reset.
REQ-007 Ports wbs_cyc_i, wbs_stb_i, wbs_we_i, input, 1 each, Wishbone classic slave controls.
REQ-008 Ports wbs_sel_i (4), wbs_adr_i (32), wbs_dat_i (32), input, Wishbone byte select, address and write data.
REQ-009 Ports wbs_ack_o (1) and wbs_dat_o (32), output, Wishbone acknowledge and read data.
REQ-010 Ports core_req_o (1), core_we_o (1), core_sel_o (4), core_addr_o (32), core_wdata_o (32), output, request to the downstream IMC core.
REQ-011 Ports core_done_i (1) and core_rdata_i (32), input, completion and read data from the IMC core.
REQ-012 Port irq_o, output, 1, one-cycle pulse on each timeout.

Function
REQ-013 Select SHALL equal wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR).
REQ-014 FSM states SHALL be IDLE, WAIT and ACK.
REQ-015 IDLE with select and wbs_adr_i[15:0]==STATUS_OFS SHALL go to ACK; a status read returns the status word, and a status write with wbs_dat_i[0]=1 clears all sticky fields.
REQ-016 IDLE with select on any other offset SHALL latch adr, we, sel and dat_i into the core_* registers, clear the wait counter and go to WAIT.
REQ-017 core_req_o SHALL be 1 exactly while in WAIT; core_* outputs SHALL stay stable throughout WAIT.
REQ-018 In WAIT, core_done_i=1 SHALL capture core_rdata_i (reads) or zero (writes) into the read register and go to ACK.
REQ-019 In WAIT, when the counter reaches TIMEOUT without done, the block SHALL set timeout_flag, increment timeout_cnt (8-bit, saturating at 255), load 32'hDEAD_BEEF into the read register, pulse irq_o and go to ACK.
REQ-020 done and timeout in the same cycle: done SHALL win; no flag, no irq.
REQ-021 wbs_cyc_i low in WAIT SHALL abort: go to IDLE next cycle, no ack, increment abort_cnt (8-bit, saturating).
REQ-022 ACK SHALL assert wbs_ack_o for exactly one cycle with wbs_dat_o = read register, then return to IDLE.
REQ-023 wbs_dat_o SHALL be 32'h0 whenever wbs_ack_o is 0.
REQ-024 core_done_i outside WAIT SHALL be ignored.
REQ-025 Latency: status access ack 1 cycle after select; core access ack 1 cycle after the done cycle (minimum 2 cycles after select).
REQ-026 Status word: [0] timeout_flag, [7:1] zero, [15:8] timeout_cnt, [23:16] abort_cnt, [31:24] 8'h01 version.

Reset
REQ-027 wb_rst_i high at an edge SHALL force IDLE, zero all outputs, counters, flags and latched registers, including mid-WAIT; no ack is issued for the interrupted transfer.

Structure
REQ-028 State encoding, STATUS version constant and 32'hDEAD_BEEF timeout pattern SHALL live in shared package imc_pkg.
REQ-029 The wait counter with terminal-count compare SHALL be sub-module imc_timeout_cnt; everything else is flat.

Verification
REQ-030 Write 32'h0000_00A5 to 0x3000_0010, done 3 cycles after req -> core_addr_o=0x3000_0010, core_wdata_o=0xA5 stable, single ack, wbs_dat_o=0.
REQ-031 Read 0x3000_0020, done with core_rdata_i=0x1234_5678 in first WAIT cycle -> ack 2 cycles after select, wbs_dat_o=0x1234_5678.
REQ-032 Read with done never asserted -> ack after TIMEOUT cycles, data 0xDEAD_BEEF, irq_o pulse; status read returns 0x0100_0101.
REQ-033 Drop wbs_cyc_i during WAIT -> core_req_o low next cycle, no ack, status abort_cnt=1; then write 1 to status -> status reads 0x0100_0000.
REQ-034 Assert wb_rst_i mid-WAIT -> next cycle core_req_o=0, wbs_ack_o=0, status reads 0x0100_0000.
REQ-035 Access to 0x3001_0000 -> no ack, no core_req_o.
